hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised, sequential successor to the ID-stage hazard detector.
- Replaces fixed rd-compare stall rules with a per-register countdown scoreboard, so any producer latency is handled: ALU, load, and future multi-cycle MUL/DIV.
- Generates the pipeline stall for ordinary and branch/JALR consumers.
- Adds an exception drain FSM: on an environment/breakpoint exception, stall until all in-flight writes retire, report drained, and hold until released.

Parameters:
- NREG, 32, number of architectural registers (x0 hard-wired zero, never tracked).
- RADDR_W, 5, register address width; must equal clog2(NREG).
- LAT_W, 3, width of the latency field and of each scoreboard counter.
- MAX_LAT, 7, largest legal producer latency; must be <= 2^LAT_W-1.
- NORM_THRESH, 1, an ordinary consumer stalls while cnt[rs] > NORM_THRESH.
- BR_THRESH, 0, a branch/JALR consumer stalls while cnt[rs] > BR_THRESH.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_flush  in  1  ID instruction is being killed this cycle; blocks issue.
- id_rs1  in  RADDR_W  source 1 address.
- id_read1  in  1  rs1 is read.
- id_rs2  in  RADDR_W  source 2 address.
- id_read2  in  1  rs2 is read.
- id_is_br  in  1  instruction is B-type or JALR (operands resolved in ID).
- id_reg_write  in  1  instruction writes rd.
- id_rd  in  RADDR_W  destination address.
- id_lat  in  LAT_W  cycles until the result is forwardable to EX (ALU=1, LOAD=2).
- exc_req  in  1  environment or breakpoint exception request, level.
- exc_resume  in  1  one-cycle pulse releasing the exception hold.
- stall  out  1  freeze PC/IF-ID, bubble into ID-EX.
- exc_drained  out  1  pipeline drained, exception handler may proceed.
- sb_busy  out  NREG  bit r = (cnt[r] != 0); bit 0 is always 0.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All cnt[] = 0, FSM = IDLE.
  - While rst=1: stall=0, exc_drained=0, sb_busy=0.
  - A reset mid-drain or mid-hold returns the block to IDLE.
- Data hazard (combinational, from current registered counters):
  - haz_s = id_valid & id_read_s & (id_rs_s != 0) & (cnt[id_rs_s] > thr), for s = 1, 2.
  - thr = BR_THRESH if id_is_br, else NORM_THRESH.
  - data_stall = haz_1 | haz_2.
  - stall = data_stall | (FSM != IDLE).
- Issue:
  - issue = id_valid & !stall & !id_flush & id_reg_write & (id_rd != 0) & (id_lat != 0).
- Counter update, every cycle:
  - Each nonzero cnt[r] decrements by 1 and saturates at 0.
  - On issue, cnt[id_rd] loads min(id_lat, MAX_LAT); the load overrides the decrement for that register in the same cycle.
  - Counters keep decrementing while stalled. Stall therefore self-releases and the block cannot deadlock.
- Resulting defaults: ALU->normal 0 stalls; LOAD->normal 1; ALU->branch 1; LOAD->branch 2.
- FSM states:
  - IDLE: on exc_req=1 -> DRAIN.
  - DRAIN: stall=1; when all cnt[]=0 -> HOLD on the next edge. exc_req is ignored in this state.
  - HOLD: stall=1, exc_drained=1; on exc_resume=1 -> IDLE. exc_resume in any other state is ignored.
- Simultaneous exc_req and issue in IDLE: the issue completes; DRAIN follows on the next cycle.
- x0 as a source never stalls. x0 as a destination is never tracked.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_data_stall[31:0] and perf_exc_stall[31:0].
  - perf_data_stall increments on each cycle with data_stall=1 and FSM=IDLE.
  - perf_exc_stall increments on each cycle with FSM != IDLE.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- LOAD x5 (lat=2), then ADD x6,x5,x1 (normal): stall=1 for exactly 1 cycle; sb_busy[5] is 1 for 2 cycles.
- ADDI x7 (lat=1), then BEQ x7,x0: stall=1 for 1 cycle. LOAD x7, then BEQ x7: stall=1 for 2 cycles.
- Issue to x0 with lat=2, then read x0: no stall; sb_busy=0.
- Producer lat=7 to x9, then consumer of x9: 6 stall cycles. An unrelated consumer of x3 does not stall.
- exc_req pulse while cnt[4]=2: stall rises next cycle and stays high. exc_drained=1 after the counters reach 0. exc_resume returns to IDLE and stall=0 on the following cycle.
- rst asserted during HOLD: the next cycle shows stall=0, exc_drained=0, sb_busy=0. With HAZ_PERF_CNT_EN, both perf counters read 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard driving the ID-stage stall, plus an exception drain FSM.
// Latency: stall/sb_busy/exc_drained are combinational from registered counters and state; counters update every edge.
// Backpressure: stall freezes ID while counters keep counting down. Optional macro HAZ_PERF_CNT_EN adds perf counters.
module hazard_scoreboard #(
  parameter int NREG        = 32,
  parameter int RADDR_W     = 5,
  parameter int LAT_W       = 3,
  parameter int MAX_LAT     = 7,
  parameter int NORM_THRESH = 1,
  parameter int BR_THRESH   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               id_flush,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic               id_read1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic               id_read2,
  input  logic               id_is_br,
  input  logic               id_reg_write,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [LAT_W-1:0]   id_lat,
  input  logic               exc_req,
  input  logic               exc_resume,
  output logic               stall,
  output logic               exc_drained,
  output logic [NREG-1:0]    sb_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_data_stall,
  output logic [31:0]        perf_exc_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_HOLD} state_t;

  localparam logic [LAT_W-1:0] L_NORM = LAT_W'(NORM_THRESH);
  localparam logic [LAT_W-1:0] L_BR   = LAT_W'(BR_THRESH);
  localparam logic [LAT_W-1:0] L_MAX  = LAT_W'(MAX_LAT);

  state_t           r_state;
  logic             r_fsm_stall;
  logic             r_drained;
  logic [LAT_W-1:0] r_cnt [NREG];

  logic [LAT_W-1:0] w_thr;
  logic [LAT_W-1:0] w_lat_clip;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_data_stall;
  logic             w_stall;
  logic             w_issue;
  logic [NREG-1:0]  w_busy;
  logic             w_all_zero;

  // Hazard detection against the current counters; branches resolve in ID so they need a lower threshold.
  always_comb begin
    w_thr        = id_is_br ? L_BR : L_NORM;
    w_haz1       = id_valid & id_read1 & (id_rs1 != '0) & (r_cnt[id_rs1] > w_thr);
    w_haz2       = id_valid & id_read2 & (id_rs2 != '0) & (r_cnt[id_rs2] > w_thr);
    w_data_stall = w_haz1 | w_haz2;
    w_stall      = w_data_stall | r_fsm_stall;
    w_lat_clip   = (id_lat > L_MAX) ? L_MAX : id_lat;
    w_issue      = id_valid & ~w_stall & ~id_flush & id_reg_write & (id_rd != '0) & (id_lat != '0);
  end

  // Busy vector and drain-complete detect; x0 is never tracked.
  always_comb begin
    w_busy = '0;
    for (int r = 1; r < NREG; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
    w_all_zero = ~|w_busy;
  end

  // Outputs are forced low while reset is held so the pipeline sees a quiet block before the first edge.
  assign stall       = w_stall & ~rst;
  assign exc_drained = r_drained & ~rst;
  assign sb_busy     = rst ? '0 : w_busy;

  // Countdown counters: saturating decrement each cycle, issue load wins for its own register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      r_cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (w_issue && (id_rd == RADDR_W'(r))) begin
          r_cnt[r] <= w_lat_clip;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  // Exception drain FSM with registered stall/drained flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fsm_stall <= 1'b0;
      r_drained   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (exc_req) begin
            r_state     <= S_DRAIN;
            r_fsm_stall <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_all_zero) begin
            r_state   <= S_HOLD;
            r_drained <= 1'b1;
          end
        end
        S_HOLD: begin
          if (exc_resume) begin
            r_state     <= S_IDLE;
            r_fsm_stall <= 1'b0;
            r_drained   <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_fsm_stall <= 1'b0;
          r_drained   <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_perf_data;
  logic [31:0] r_perf_exc;

  // Saturating stall-cycle counters, split into data-hazard stalls and exception stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_data <= '0;
      r_perf_exc  <= '0;
    end else begin
      if (w_data_stall && (r_state == S_IDLE) && (r_perf_data != '1)) begin
        r_perf_data <= r_perf_data + 32'd1;
      end
      if ((r_state != S_IDLE) && (r_perf_exc != '1)) begin
        r_perf_exc <= r_perf_exc + 32'd1;
      end
    end
  end

  assign perf_data_stall = r_perf_data;
  assign perf_exc_stall  = r_perf_exc;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random stimulus against a ready-time reference model.
// Expected outputs are queued per cycle by the driver and compared by an independent monitor.
// Optional macro HAZ_PERF_CNT_EN also checks the perf counters.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        id_valid = 1'b0, id_flush = 1'b0, id_read1 = 1'b0, id_read2 = 1'b0;
  logic        id_is_br = 1'b0, id_reg_write = 1'b0, exc_req = 1'b0, exc_resume = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0]  id_lat = '0;
  logic        stall, exc_drained;
  logic [31:0] sb_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_data_stall, perf_exc_stall;
`endif

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs1(id_rs1), .id_read1(id_read1), .id_rs2(id_rs2), .id_read2(id_read2),
    .id_is_br(id_is_br), .id_reg_write(id_reg_write), .id_rd(id_rd), .id_lat(id_lat),
    .exc_req(exc_req), .exc_resume(exc_resume),
    .stall(stall), .exc_drained(exc_drained), .sb_busy(sb_busy)
`ifdef HAZ_PERF_CNT_EN
    , .perf_data_stall(perf_data_stall), .perf_exc_stall(perf_exc_stall)
`endif
  );

  typedef struct packed {
    logic       rst, valid, flush, rd1, rd2, br, rw, exr, exres;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] lat;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        stall;
    logic        drained;
    logic [31:0] busy;
    logic [31:0] pd;
    logic [31:0] pe;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: each register is busy until an absolute cycle number.
  int          ready[32];
  int          t = 0;
  int          mode = 0;  // 0 idle, 1 draining, 2 holding
  logic [31:0] m_pd = '0;
  logic [31:0] m_pe = '0;

  function automatic int mcnt(input int r);
    if (r == 0) return 0;
    return (ready[r] > t) ? ready[r] - t : 0;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    int   thr;
    bit   h1, h2, ds, st, iss, allz;
    int   lat;
    @(posedge clk);
    #1;
    rst = s.rst; id_valid = s.valid; id_flush = s.flush; id_read1 = s.rd1; id_read2 = s.rd2;
    id_is_br = s.br; id_reg_write = s.rw; exc_req = s.exr; exc_resume = s.exres;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_lat = s.lat;
    thr = s.br ? 0 : 1;
    h1 = s.valid && s.rd1 && (s.rs1 != 0) && (mcnt(int'(s.rs1)) > thr);
    h2 = s.valid && s.rd2 && (s.rs2 != 0) && (mcnt(int'(s.rs2)) > thr);
    ds = h1 || h2;
    st = ds || (mode != 0);
    e.cyc = t;
    e.busy = '0;
    allz = 1'b1;
    for (int r = 1; r < 32; r++) begin
      if (mcnt(r) > 0) begin
        e.busy[r] = 1'b1;
        allz = 1'b0;
      end
    end
    if (s.rst) begin
      e.stall = 1'b0; e.drained = 1'b0; e.busy = '0;
    end else begin
      e.stall = st; e.drained = (mode == 2);
    end
    e.pd = m_pd;
    e.pe = m_pe;
    q.push_back(e);
    if (s.rst) begin
      for (int r = 0; r < 32; r++) ready[r] = 0;
      mode = 0; m_pd = '0; m_pe = '0;
    end else begin
      if (ds && mode == 0 && m_pd != 32'hFFFF_FFFF) m_pd = m_pd + 1;
      if (mode != 0 && m_pe != 32'hFFFF_FFFF) m_pe = m_pe + 1;
      iss = s.valid && !st && !s.flush && s.rw && (s.rd != 0) && (s.lat != 0);
      if (iss) begin
        lat = (int'(s.lat) > 7) ? 7 : int'(s.lat);
        ready[s.rd] = t + 1 + lat;
      end
      case (mode)
        0: if (s.exr) mode = 1;
        1: if (allz) mode = 2;
        2: if (s.exres) mode = 0;
        default: mode = 0;
      endcase
    end
    t++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(nop());
  endtask

  // Hold a consumer in ID while the DUT stalls it and compare the stall-cycle count.
  task automatic hold_consumer(input stim_t s, input int want, input string nm);
    int n;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(s);
      #1;
      if (stall !== 1'b1) break;
      n++;
    end
    chk(nm, t, n, want);
  endtask

  // Monitor: compare each queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", e.cyc, {31'b0, stall}, {31'b0, e.stall});
        chk("drained", e.cyc, {31'b0, exc_drained}, {31'b0, e.drained});
        chk("sb_busy", e.cyc, sb_busy, e.busy);
`ifdef HAZ_PERF_CNT_EN
        chk("perf_data", e.cyc, perf_data_stall, e.pd);
        chk("perf_exc", e.cyc, perf_exc_stall, e.pe);
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s, c, r;
    int    n;
    for (int i = 0; i < 32; i++) ready[i] = 0;
    s = nop(); s.rst = 1'b1;
    step(s);
    step(s);
    idle_n(2);

    // Load-use to ordinary consumer.
    s = nop(); s.valid = 1; s.rw = 1; s.rd = 5; s.lat = 2;
    step(s);
    c = nop(); c.valid = 1; c.rd1 = 1; c.rs1 = 5; c.rd2 = 1; c.rs2 = 1; c.rw = 1; c.rd = 6; c.lat = 1;
    hold_consumer(c, 1, "load_use");
    idle_n(8);

    // ALU and load feeding a branch.
    s = nop(); s.valid = 1; s.rd1 = 1; s.rs1 = 1; s.rw = 1; s.rd = 7; s.lat = 1;
    step(s);
    c = nop(); c.valid = 1; c.br = 1; c.rd1 = 1; c.rs1 = 7; c.rd2 = 1; c.rs2 = 0;
    hold_consumer(c, 1, "alu_branch");
    idle_n(8);
    s.lat = 2;
    step(s);
    hold_consumer(c, 2, "load_branch");
    idle_n(8);

    // x0 as destination is not tracked; as source never stalls.
    s = nop(); s.valid = 1; s.rw = 1; s.rd = 0; s.lat = 2;
    step(s);
    c = nop(); c.valid = 1; c.rd1 = 1; c.rs1 = 0; c.rd2 = 1; c.rs2 = 0; c.br = 1;
    hold_consumer(c, 0, "x0_src");
    idle_n(4);

    // Maximum latency producer, then dependent and unrelated consumers.
    s = nop(); s.valid = 1; s.rw = 1; s.rd = 9; s.lat = 7;
    step(s);
    c = nop(); c.valid = 1; c.rd1 = 1; c.rs1 = 9;
    hold_consumer(c, 6, "lat7_dep");
    c.rs1 = 3;
    hold_consumer(c, 0, "unrelated");
    idle_n(8);

    // Exception drain: pulse while cnt[4]=2, wait for drained, then resume.
    s = nop(); s.valid = 1; s.rw = 1; s.rd = 4; s.lat = 2;
    step(s);
    s = nop(); s.exr = 1;
    step(s);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(nop());
      n++;
      #1;
      if (exc_drained === 1'b1) break;
    end
    chk("drain_cycles", t, n, 3);
    s = nop(); s.exr = 1;  // ignored while holding
    idle_n(2);
    step(s);
    s = nop(); s.exres = 1;
    step(s);
    step(nop());
    #1;
    chk("resume_release", t, {31'b0, stall}, 32'd0);

    // Reset during hold.
    s = nop(); s.exr = 1;
    step(s);
    idle_n(4);
    r = nop(); r.rst = 1;
    step(r);
    step(nop());
    #1;
    chk("rst_hold_stall", t, {31'b0, stall}, 32'd0);
    chk("rst_hold_drained", t, {31'b0, exc_drained}, 32'd0);
    chk("rst_hold_busy", t, sb_busy, 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rst_perf_data", t, perf_data_stall, 32'd0);
    chk("rst_perf_exc", t, perf_exc_stall, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s = nop();
      s.rst   = ($urandom_range(0, 299) == 0);
      s.valid = ($urandom_range(0, 9) < 8);
      s.flush = ($urandom_range(0, 9) == 0);
      s.rd1   = ($urandom_range(0, 3) != 0);
      s.rd2   = ($urandom_range(0, 1) != 0);
      s.br    = ($urandom_range(0, 9) < 3);
      s.rw    = ($urandom_range(0, 3) != 0);
      s.rs1   = 5'($urandom_range(0, 7));
      s.rs2   = 5'($urandom_range(0, 7));
      s.rd    = 5'($urandom_range(0, 7));
      s.lat   = 3'($urandom_range(0, 7));
      s.exr   = ($urandom_range(0, 59) == 0);
      s.exres = ($urandom_range(0, 4) == 0);
      step(s);
    end

    idle_n(2);
    @(negedge clk);
    #1;
    chk("queue_empty", t, q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
